// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data BRAM: CPU has default priority,
// DMA is protected from starvation by a saturating wait counter and a burst lock.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_locked;
    logic             r_cpu_rvalid;
    logic             r_dma_rvalid;
    logic             w_dma_win;

    // DMA wins when locked, when alone, or when it has waited long enough.
    always_comb begin
        w_dma_win = 1'b0;
        if (dma_req && (r_locked || !cpu_req || (r_starve_cnt == STARVE_LIM))) begin
            w_dma_win = 1'b1;
        end
    end

    assign dma_gnt = !rst && w_dma_win;
    assign cpu_gnt = !rst && cpu_req && !w_dma_win;
    assign owner   = dma_gnt;

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end

    // Read data is shared; the per-port rvalid is the only qualifier.
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_locked     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= cpu_gnt && !cpu_we;
            r_dma_rvalid <= dma_gnt && !dma_we;
            r_locked     <= dma_gnt && dma_lock;
            if (!dma_req || dma_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt < STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver pushes expected grants/reads from a
// priority-rule model, a negedge monitor pops and compares against the DUT.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;

    typedef struct {
        logic          cg;
        logic          dg;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct {
        logic          is_dma;
        logic [DW-1:0] data;
        int            due;
    } rexp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
    logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we, owner;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] bram   [16];
    logic [DW-1:0] shadow [16];
    gexp_t gq[$];
    rexp_t rq[$];

    int m_waited = 0;
    bit m_locked = 1'b0;
    bit m_cg     = 1'b0;
    bit m_dg     = 1'b0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Behavioural single-port BRAM, 16 words, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= bram[mem_addr[5:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // New request values only when the port is free to change them (not waiting on a grant).
    task automatic new_cpu(input bit req, input bit we);
        if (cpu_req && !m_cg) return;
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = AW'($urandom_range(0, 15)) << 2;
        cpu_wdata = $urandom;
    endtask

    task automatic new_dma(input bit req, input bit we, input bit lock);
        dma_lock = lock;
        if (dma_req && !m_dg) return;
        dma_req   = req;
        dma_we    = we;
        dma_addr  = AW'($urandom_range(0, 15)) << 2;
        dma_wdata = $urandom;
    endtask

    // Reference: apply the priority rules to the current inputs, push expectations, advance.
    task automatic commit();
        gexp_t e;
        bit    dw, cw;
        logic [3:0] idx;
        cyc++;
        dw = dma_req && (!cpu_req || m_locked || (m_waited >= int'(SM)));
        cw = cpu_req && !dw;
        e.cg    = cw;
        e.dg    = dw;
        e.we    = dw ? dma_we : (cw ? cpu_we : 1'b0);
        e.addr  = dw ? dma_addr : cpu_addr;
        e.wdata = dw ? dma_wdata : cpu_wdata;
        gq.push_back(e);
        idx = e.addr[5:2];
        if (dw || cw) begin
            if (e.we) shadow[idx] = e.wdata;
            else      rq.push_back('{dw, shadow[idx], cyc + 1});
        end
        if (dma_req && !dw) m_waited = (m_waited < int'(SM)) ? m_waited + 1 : m_waited;
        else                m_waited = 0;
        m_locked = dw && dma_lock;
        m_cg = cw;
        m_dg = dw;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            gexp_t e;
            rexp_t r;
            if (gq.size() > 0) begin
                e = gq.pop_front();
                chk("cpu_gnt",   32'(cpu_gnt), 32'(e.cg));
                chk("dma_gnt",   32'(dma_gnt), 32'(e.dg));
                chk("owner",     32'(owner),   32'(e.dg));
                chk("mem_we",    32'(mem_we),  32'(e.we));
                chk("mem_addr",  mem_addr,     e.addr);
                chk("mem_wdata", mem_wdata,    e.wdata);
            end
            if (cpu_rvalid && dma_rvalid) chk("rvalid_both", 32'(1), 32'(0));
            if (cpu_rvalid || dma_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", 32'(1), 32'(0));
                end else begin
                    r = rq.pop_front();
                    chk("rvalid_port", 32'(dma_rvalid), 32'(r.is_dma));
                    chk("rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("rdata", dma_rvalid ? dma_rdata : cpu_rdata, r.data);
                end
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                chk("rvalid_missing", 32'(0), 32'(1));
            end
        end
    end

    // Both held: CPU four times, DMA once, repeat (starve counter starts from 0).
    task automatic contention(input string tag);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            new_cpu(1'b1, 1'b0);
            new_dma(1'b1, 1'b0, 1'b0);
            commit();
            @(negedge clk); #1;
            chk({tag, "_dma_gnt"}, 32'(dma_gnt), 32'(i == 4 || i == 9));
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            new_cpu($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)));
            new_dma($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            commit();
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            new_cpu(1'b0, 1'b0);
            new_dma(1'b0, 1'b0, 1'b0);
            commit();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            bram[i]   = $urandom;
            shadow[i] = bram[i];
        end
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = '0; dma_wdata = '0; dma_lock = 1'b1;
        #3;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'(0));
        chk("rst_dma_gnt", 32'(dma_gnt), 32'(0));
        chk("rst_mem_we",  32'(mem_we),  32'(0));
        chk("rst_owner",   32'(owner),   32'(0));
        chk("rst_rvalid",  32'({cpu_rvalid, dma_rvalid}), 32'(0));
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        contention("init");
        run_random(250);

        // Idle: the model expects no grant, no write, owner 0, no rvalid.
        drain(8);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            commit();
            @(negedge clk); #1;
            chk("idle_outputs", 32'({cpu_gnt, dma_gnt, mem_we, owner, cpu_rvalid, dma_rvalid}), 32'(0));
        end

        // DMA burst writes under lock while the CPU waits.
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hA0A0_0100; dma_lock = 1'b1;
        commit();
        @(negedge clk); #1;
        chk("lock0_dma_gnt", 32'({dma_gnt, mem_we, owner}), 32'h7);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_addr = 32'h104; dma_wdata = 32'hA0A0_0104;
        commit();
        @(negedge clk); #1;
        chk("lock1_dma_gnt", 32'({dma_gnt, cpu_gnt, mem_we, owner}), 32'hB);
        @(posedge clk); #1;
        dma_addr = 32'h108; dma_wdata = 32'hA0A0_0108; dma_lock = 1'b0;
        commit();
        @(negedge clk); #1;
        chk("lock2_dma_gnt", 32'({dma_gnt, cpu_gnt, mem_we, owner}), 32'hB);
        @(posedge clk); #1;
        dma_addr = 32'h10C; dma_wdata = 32'hA0A0_010C;
        commit();
        @(negedge clk); #1;
        chk("unlock_cpu_gnt", 32'({cpu_gnt, dma_gnt}), 32'h2);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        commit();
        drain(8);

        // Reset asserted between edges while a read is in flight.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
        commit();
        @(posedge clk); #1;
        cpu_addr = 32'h108;
        commit();
        @(negedge clk); #1;
        chk("pre_rst_cpu_rvalid", 32'(cpu_rvalid), 32'(1));
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'(0));
        chk("midrst_gnt",    32'({cpu_gnt, dma_gnt}), 32'(0));
        chk("midrst_mem_we", 32'(mem_we), 32'(0));
        gq.delete();
        rq.delete();
        m_waited = 0; m_locked = 1'b0; m_cg = 1'b0; m_dg = 1'b0;
        @(posedge clk); #1;
        chk("rst_edge_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'(0));
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        contention("post_rst");
        run_random(300);
        drain(10);
        @(negedge clk); #1;
        chk("queues_empty", 32'(gq.size() + rq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data-memory BRAM between two requesters: the CPU pipeline data port (CPU) and a loader/debug DMA port (DMA).
- Grants at most one access per cycle and drives the BRAM address, write-enable and write-data.
- Returns read data with the BRAM's fixed 1-cycle latency, tagged by a per-port rvalid pulse.
- CPU has default priority; a starvation counter and a DMA lock (burst) mechanism bound DMA waiting time.

Parameters:
- ADDR_W, 32, requester/memory address width (byte address; word index taken downstream).
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied DMA request cycles after which DMA wins the next contended cycle; legal range 1..255.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; hold req/we/addr/wdata stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  DATA_W  CPU read data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA equivalents of the CPU inputs
- dma_lock  in  1  when high with a granted DMA access, DMA keeps ownership next cycle
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DATA_W  DMA equivalents of the CPU outputs
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data, valid 1 cycle after address
- owner  out  1  0 = CPU path selected, 1 = DMA path selected (combinational; mirrors mux select)

Behaviour:
- Reset (async, active-high): starve_cnt = 0, locked = 0, cpu_rvalid = dma_rvalid = 0, rd_owner = 0.
- While rst is high: cpu_gnt = dma_gnt = 0 and mem_we = 0.
- Arbitration (combinational, each cycle T), highest rule wins:
  1. locked && dma_req -> DMA.
  2. Both requesting and starve_cnt == STARVE_MAX -> DMA.
  3. cpu_req -> CPU.
  4. dma_req -> DMA.
  5. Otherwise no grant.
- Grant exclusivity: exactly one gnt or none; cpu_gnt && dma_gnt is never 1.
- Memory mux: owner = 1 iff DMA is granted; otherwise CPU inputs are muxed through.
  - mem_addr and mem_wdata follow the selected port.
  - mem_we = granted port's we; 0 when no grant.
- Read latency: a granted read in cycle T sets <port>_rvalid = 1 in cycle T+1 for exactly one cycle.
  - cpu_rdata and dma_rdata both equal mem_rdata continuously; rvalid is the only qualifier.
  - Writes never raise rvalid.
- Back-to-back: a new grant is allowed every cycle; reads in T and T+1 produce rvalid in T+1 and T+2 with no bubble.
  - Owner may change between consecutive cycles.
- starve_cnt (8-bit, saturating at STARVE_MAX):
  - Increments when dma_req = 1 and dma_gnt = 0.
  - Clears on dma_gnt or when dma_req = 0.
- locked: next = dma_gnt && dma_lock. Clears when DMA drops dma_req or dma_lock, or on reset.
  - While locked and dma_req is high, the CPU waits indefinitely; the CPU pipeline must stall on !cpu_gnt.
- Simultaneous write/read: no same-cycle collision is possible (single grant), so no forwarding is needed.
- Reset mid-read: a read granted in the reset-asserting cycle produces no rvalid.

Test Plan:
- CPU only: cpu read addr 0x10 with mem_rdata = 0xDEADBEEF next cycle -> cpu_gnt in T, mem_addr = 0x10, mem_we = 0, cpu_rvalid = 1 in T+1, cpu_rdata = 0xDEADBEEF, dma_rvalid = 0.
- Contention/starvation, STARVE_MAX = 4: cpu_req and dma_req held high continuously -> CPU granted T..T+3, DMA granted T+4, counter cleared, CPU granted T+5..T+8, DMA T+9.
- DMA burst lock: dma_req = dma_lock = 1 writing 0x100, 0x104, 0x108 while cpu_req high -> dma_gnt 3 consecutive cycles, mem_we = 1, owner = 1; dropping dma_lock -> CPU granted the following cycle.
- Interleaved reads: CPU read T, DMA read T+1 (mem_rdata 0x11 then 0x22) -> cpu_rvalid with 0x11 at T+1, dma_rvalid with 0x22 at T+2, never both high.
- Async reset mid-operation: assert rst between clock edges during a granted read -> rvalids drop to 0 immediately, no rvalid after release, gnts = 0 and mem_we = 0 while rst high, starve_cnt = 0.
- Idle: no requests for 10 cycles -> mem_we = 0, both gnt = 0, both rvalid = 0, owner = 0.
